fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_queue.sv | 52 +++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and defaults for the fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    localparam int unsigned FETCH_RESET_PC = 0;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - power-of-two FIFO holding {pc, instr} with flush and count
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_pop;

    assign w_do_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Head is forced to zero while empty so stale storage never leaks out.
    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with epoch-tagged responses and fetch queue
module fetch_unit import fetch_pkg::*; #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                FQ_DEPTH = 4,
    parameter int                PC_STEP  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_base,
    input  logic [ADDR_W-1:0]  redirect_offset,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               busy
);

    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    fetch_state_e        r_state;
    fetch_state_e        w_state_next;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic [ADDR_W-1:0]   r_pend_pc;
    logic                r_pend;
    logic                r_pend_epoch;
    logic                r_epoch;
    logic [CNT_W-1:0]    w_count;
    logic [CNT_W:0]      w_used;
    logic                w_room;
    logic                w_req;
    logic                w_push;
    logic                w_pop;
    logic [ADDR_W-1:0]   w_target;
    logic [ADDR_W+INSTR_W-1:0] w_head;

    // Memory answers exactly one cycle later, so at most one request is outstanding.
    assign w_used   = {1'b0, w_count} + (CNT_W+1)'(r_pend);
    assign w_room   = w_used < (CNT_W+1)'(FQ_DEPTH);
    assign w_target = redirect_base + redirect_offset;

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !redirect_valid) begin
                    w_state_next = ST_RUN;
                    w_req        = !reset && w_room;
                end
            end
            ST_RUN: begin
                if (redirect_valid) w_state_next = ST_FLUSH;
                else                w_req        = !reset && w_room;
            end
            ST_FLUSH: begin
                w_state_next = redirect_valid ? ST_FLUSH : ST_RUN;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_pend       <= 1'b0;
            r_pend_pc    <= '0;
            r_pend_epoch <= 1'b0;
            r_epoch      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_req;
            if (w_req) begin
                r_pend_pc    <= r_fetch_pc;
                r_pend_epoch <= r_epoch;
            end
            if (redirect_valid) begin
                r_fetch_pc <= w_target;
                if (r_state != ST_IDLE) r_epoch <= ~r_epoch;
            end else if (w_req) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
            end
        end
    end

    // A response from an older epoch, or one landing on a redirect, is dropped.
    assign w_push = imem_rvalid && r_pend && (r_pend_epoch == r_epoch)
                    && !redirect_valid && (r_state == ST_RUN);
    assign w_pop  = out_valid && out_ready && !redirect_valid;

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (ADDR_W + INSTR_W)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({r_pend_pc, imem_rdata}),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_valid (out_valid),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign out_pc    = w_head[ADDR_W+INSTR_W-1:INSTR_W];
    assign out_instr = w_head[INSTR_W-1:0];
    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc;
    assign busy      = (r_state != ST_IDLE);

endmodule
